// File: rtl/div_pkg.sv
// Shared types for the repeated-subtraction divider.
// State encoding and default operand width.
package div_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LDB  = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_if.sv
// Operand/result bundle for the divider.
// master drives operands; slave is the divider.
interface div_if #(
  parameter int WIDTH = 16
) ();

  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic             dbz;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, data_in,
    input  busy, done, dbz,
    input  quotient, remainder
  );

  modport slave (
    input  start, data_in,
    output busy, done, dbz,
    output quotient, remainder
  );

endinterface

// File: rtl/div_datapath.sv
// Remainder/divisor registers, quotient counter,
// subtractor and the R>=D / D==0 comparators.
module div_datapath #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ldR,
  input  logic             ldD,
  input  logic             clrQ,
  input  logic             incQ,
  input  logic             selSub,
  input  logic [WIDTH-1:0] din,
  output logic             ge,
  output logic             dz,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] diff;

  assign diff = r_q - d_q;
  assign ge   = (r_q >= d_q);
  assign dz   = (d_q == '0);
  assign q    = q_q;
  assign r    = r_q;

  always_comb begin
    r_d = r_q;
    d_d = d_q;
    q_d = q_q;
    if (ldR) r_d = selSub ? diff : din;
    if (ldD) d_d = din;
    if (clrQ)      q_d = '0;
    else if (incQ) q_d = q_q + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
      d_q <= '0;
      q_q <= '0;
    end else begin
      r_q <= r_d;
      d_q <= d_d;
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/div_repsub.sv
// Unsigned divider by repeated subtraction.
// Controller FSM here; arithmetic lives in div_datapath.
module div_repsub
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic   clk,
  input logic   rst,
  div_if.slave  bus
);

  state_t state_q, state_d;
  logic   dbz_q, dbz_d;
  logic   ldR, ldD, clrQ, incQ, selSub;
  logic   ge, dz;

  div_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk    (clk),
    .rst    (rst),
    .ldR    (ldR),
    .ldD    (ldD),
    .clrQ   (clrQ),
    .incQ   (incQ),
    .selSub (selSub),
    .din    (bus.data_in),
    .ge     (ge),
    .dz     (dz),
    .q      (bus.quotient),
    .r      (bus.remainder)
  );

  always_comb begin
    state_d = state_q;
    dbz_d   = dbz_q;
    ldR     = 1'b0;
    ldD     = 1'b0;
    clrQ    = 1'b0;
    incQ    = 1'b0;
    selSub  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          ldR     = 1'b1;
          clrQ    = 1'b1;
          dbz_d   = 1'b0;
          state_d = LDB;
        end
      end
      LDB: begin
        ldD     = 1'b1;
        state_d = CALC;
      end
      CALC: begin
        // zero divisor must exit, else R>=0 loops forever
        if (dz) begin
          dbz_d   = 1'b1;
          state_d = DONE;
        end else if (ge) begin
          ldR    = 1'b1;
          selSub = 1'b1;
          incQ   = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.dbz  = dbz_q;

endmodule
